// File: rtl/sumador_pkg.sv
// Purpose: shared types and sizing helpers for the multi-nibble adder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sumador_pkg;

    // Width of one adder slice; the wide operands are walked in steps of this size
    localparam int BITS_NIBBLE = 4;

    // Sequencer states: idle/accepting, nibble-serial add, result hand-off
    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    // Operand width in bits for a given nibble count
    function automatic int ancho_operando(input int n_nibbles);
        return n_nibbles * BITS_NIBBLE;
    endfunction

endpackage

// File: rtl/full_adder_4bit.sv
// Purpose: combinational 4-bit adder with carry-in/carry-out, one nibble slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller sequences operands into it.
module full_adder_4bit
    import sumador_pkg::*;
(
    input  logic [BITS_NIBBLE-1:0] i_a,
    input  logic [BITS_NIBBLE-1:0] i_b,
    input  logic                   i_acarreo,
    output logic [BITS_NIBBLE-1:0] o_suma,
    output logic                   o_acarreo
);

    // One bit wider than a nibble so the carry-out falls out of the addition
    logic [BITS_NIBBLE:0] w_total;

    assign w_total   = {1'b0, i_a} + {1'b0, i_b} + {{BITS_NIBBLE{1'b0}}, i_acarreo};
    assign o_suma    = w_total[BITS_NIBBLE-1:0];
    assign o_acarreo = w_total[BITS_NIBBLE];

endmodule

// File: rtl/sumador_multinibble.sv
// Purpose: nibble-serial wide adder (A+B+cin mod 2^W) around one full_adder_4bit; optional
//          signed-overflow output o_desborde when SUMADOR_MULTINIBBLE_DESBORDE_EN is defined.
// Latency: N_NIBBLES edges from acceptance to o_valido; minimum N_NIBBLES+2 cycles per addition.
// Backpressure: o_listo only in REPOSO; result held stable in ENTREGA until i_listo, no bypass.
module sumador_multinibble
    import sumador_pkg::*;
#(
    parameter  int N_NIBBLES = 4,
    localparam int W         = ancho_operando(N_NIBBLES)
)(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valido,
    output logic         o_listo,
    input  logic [W-1:0] i_operando_a,
    input  logic [W-1:0] i_operando_b,
    input  logic         i_acarreo,
    output logic         o_valido,
    input  logic         i_listo,
    output logic [W-1:0] o_suma,
    output logic         o_acarreo,
    output logic         o_ocupado
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
    ,
    output logic         o_desborde
`endif
);

    // Counter wide enough to hold N_NIBBLES itself
    localparam int            CW     = $clog2(N_NIBBLES + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(N_NIBBLES - 1);
    localparam logic [CW-1:0] UNO    = CW'(1);

    estado_t          r_estado;
    logic [W-1:0]     r_op_a;
    logic [W-1:0]     r_op_b;
    logic [W-1:0]     r_suma;
    logic             r_acarreo;
    logic             r_acarreo_sal;
    logic             r_valido;
    logic [CW-1:0]    r_cuenta;

    logic [BITS_NIBBLE-1:0] w_nib_a;
    logic [BITS_NIBBLE-1:0] w_nib_b;
    logic [BITS_NIBBLE-1:0] w_nib_suma;
    logic                   w_cout;
    logic                   w_ultimo;
    logic [W+BITS_NIBBLE-1:0] w_suma_ext;

`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
    logic r_desborde;
    logic w_acarreo_msb;
    logic w_desborde;
`endif

    // The low nibble of each shift register is always the one being added
    assign w_nib_a  = r_op_a[BITS_NIBBLE-1:0];
    assign w_nib_b  = r_op_b[BITS_NIBBLE-1:0];
    assign w_ultimo = (r_cuenta == ULTIMO);

    // New nibble enters at the MSB end; after N_NIBBLES shifts the LSB nibble sits at the bottom.
    // Concatenate-and-drop keeps this valid for N_NIBBLES == 1 where there is no upper slice.
    assign w_suma_ext = {w_nib_suma, r_suma};

`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
    // Carry into the top bit recovered from a ^ b ^ sum of that bit; overflow when it differs from carry-out
    assign w_acarreo_msb = w_nib_a[BITS_NIBBLE-1] ^ w_nib_b[BITS_NIBBLE-1] ^ w_nib_suma[BITS_NIBBLE-1];
    assign w_desborde    = w_acarreo_msb ^ w_cout;
`endif

    full_adder_4bit u_full_adder_4bit (
        .i_a       (w_nib_a),
        .i_b       (w_nib_b),
        .i_acarreo (r_acarreo),
        .o_suma    (w_nib_suma),
        .o_acarreo (w_cout)
    );

    // Sequencer: capture operands, walk them nibble by nibble, then hold the result until taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_estado      <= REPOSO;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_suma        <= '0;
            r_acarreo     <= 1'b0;
            r_acarreo_sal <= 1'b0;
            r_valido      <= 1'b0;
            r_cuenta      <= '0;
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
            r_desborde    <= 1'b0;
`endif
        end else begin
            case (r_estado)
                REPOSO: begin
                    // o_listo is implied by being in this state
                    if (i_valido) begin
                        r_op_a    <= i_operando_a;
                        r_op_b    <= i_operando_b;
                        r_acarreo <= i_acarreo;
                        r_cuenta  <= '0;
                        r_estado  <= SUMANDO;
                    end
                end
                SUMANDO: begin
                    r_suma    <= w_suma_ext[W+BITS_NIBBLE-1:BITS_NIBBLE];
                    r_acarreo <= w_cout;
                    r_op_a    <= r_op_a >> BITS_NIBBLE;
                    r_op_b    <= r_op_b >> BITS_NIBBLE;
                    r_cuenta  <= r_cuenta + UNO;
                    if (w_ultimo) begin
                        r_acarreo_sal <= w_cout;
                        r_valido      <= 1'b1;
                        r_estado      <= ENTREGA;
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
                        r_desborde    <= w_desborde;
`endif
                    end
                end
                ENTREGA: begin
                    // Result and flags stay frozen until the consumer takes them
                    if (r_valido && i_listo) begin
                        r_valido <= 1'b0;
                        r_estado <= REPOSO;
                    end
                end
                default: begin
                    r_estado <= REPOSO;
                    r_valido <= 1'b0;
                end
            endcase
        end
    end

    assign o_listo   = (r_estado == REPOSO);
    assign o_ocupado = (r_estado == SUMANDO) || (r_estado == ENTREGA);
    assign o_valido  = r_valido;
    assign o_suma    = r_suma;
    assign o_acarreo = r_acarreo_sal;
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
    assign o_desborde = r_desborde;
`endif

endmodule

// File: tb/tb_sumador_multinibble.sv
// Purpose: self-checking bench for sumador_multinibble at N_NIBBLES=4 and N_NIBBLES=1.
// Latency: expects N_NIBBLES edges from acceptance to o_valido.
// Backpressure: exercises held i_listo, held i_valido during ENTREGA and mid-operation reset.
module tb_sumador_multinibble;

    logic        clk;
    logic        rst_n;

    logic        valido, listo, acarreo;
    logic [15:0] op_a, op_b;
    logic        o_listo, o_valido, o_acarreo, o_ocupado;
    logic [15:0] o_suma;
    logic        o_desborde;

    logic        v1, l1, ci1;
    logic [3:0]  a1, b1;
    logic        ol1, ov1, co1, oc1;
    logic [3:0]  s1;
    logic        d1;

    int checks   = 0;
    int failures = 0;

    sumador_multinibble #(.N_NIBBLES(4)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valido     (valido),
        .o_listo      (o_listo),
        .i_operando_a (op_a),
        .i_operando_b (op_b),
        .i_acarreo    (acarreo),
        .o_valido     (o_valido),
        .i_listo      (listo),
        .o_suma       (o_suma),
        .o_acarreo    (o_acarreo),
        .o_ocupado    (o_ocupado)
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
        ,
        .o_desborde   (o_desborde)
`endif
    );

    sumador_multinibble #(.N_NIBBLES(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valido     (v1),
        .o_listo      (ol1),
        .i_operando_a (a1),
        .i_operando_b (b1),
        .i_acarreo    (ci1),
        .o_valido     (ov1),
        .i_listo      (l1),
        .o_suma       (s1),
        .o_acarreo    (co1),
        .o_ocupado    (oc1)
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
        ,
        .o_desborde   (d1)
`endif
    );

`ifndef SUMADOR_MULTINIBBLE_DESBORDE_EN
    assign o_desborde = 1'b0;
    assign d1         = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the whole operands
    function automatic logic [16:0] modelo16(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction

    function automatic logic ovf16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int sa;
        sa = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
        return (sa > 32767) || (sa < -32768);
    endfunction

    function automatic logic [4:0] modelo4(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction

    function automatic logic ovf4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int sa;
        sa = int'($signed(a)) + int'($signed(b)) + (c ? 1 : 0);
        return (sa > 7) || (sa < -8);
    endfunction

    // Stimulus only: one full transaction on the N=4 instance, returns what was observed.
    // Caller must be at posedge+#1. lat = -1 when a bounded wait expires.
    task automatic enviar(input logic [15:0] a, input logic [15:0] b, input logic cin, input int espera,
                          output int lat, output logic [15:0] s, output logic c, output logic d);
        int n;
        n = 0;
        while (o_listo !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        valido = 1'b1; op_a = a; op_b = b; acarreo = cin;
        @(posedge clk); #1;
        valido = 1'b0;
        n = 0;
        while (o_valido !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        lat = (o_valido === 1'b1) ? n : -1;
        s = o_suma; c = o_acarreo; d = o_desborde;
        repeat (espera) begin @(posedge clk); #1; end
        listo = 1'b1;
        @(posedge clk); #1;
        listo = 1'b0;
    endtask

    // Same transaction on the N=1 instance
    task automatic enviar1(input logic [3:0] a, input logic [3:0] b, input logic cin, input int espera,
                           output int lat, output logic [3:0] s, output logic c, output logic d);
        int n;
        n = 0;
        while (ol1 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        v1 = 1'b1; a1 = a; b1 = b; ci1 = cin;
        @(posedge clk); #1;
        v1 = 1'b0;
        n = 0;
        while (ov1 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        lat = (ov1 === 1'b1) ? n : -1;
        s = s1; c = co1; d = d1;
        repeat (espera) begin @(posedge clk); #1; end
        l1 = 1'b1;
        @(posedge clk); #1;
        l1 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_valido !== 1'b0) begin failures++; $display("FAIL rst_in_valido: got %b want 0", o_valido); end
        checks++; if (o_suma !== 16'h0000) begin failures++; $display("FAIL rst_in_suma: got %h want 0000", o_suma); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL rst_listo: got %b want 1", o_listo); end
        checks++; if (o_valido !== 1'b0) begin failures++; $display("FAIL rst_valido: got %b want 0", o_valido); end
        checks++; if (o_suma !== 16'h0000) begin failures++; $display("FAIL rst_suma: got %h want 0000", o_suma); end
        checks++; if (o_acarreo !== 1'b0) begin failures++; $display("FAIL rst_acarreo: got %b want 0", o_acarreo); end
        checks++; if (o_ocupado !== 1'b0) begin failures++; $display("FAIL rst_ocupado: got %b want 0", o_ocupado); end
        checks++; if (o_desborde !== 1'b0) begin failures++; $display("FAIL rst_desborde: got %b want 0", o_desborde); end
        checks++; if (ol1 !== 1'b1) begin failures++; $display("FAIL rst_listo_n1: got %b want 1", ol1); end
    endtask

    task automatic test_wrap;
        int lat; logic [15:0] s; logic c, d;
        enviar(16'hFFFF, 16'h0001, 1'b0, 0, lat, s, c, d);
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL wrap_suma: got %h want 0000", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL wrap_acarreo: got %b want 1", c); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL wrap_latencia: got %0d want 4", lat); end
        checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL wrap_listo_after: got %b want 1", o_listo); end
        checks++; if (o_acarreo !== 1'b1) begin failures++; $display("FAIL wrap_acarreo_hold: got %b want 1", o_acarreo); end
    endtask

    task automatic test_backpressure;
        int n;
        valido = 1'b1; op_a = 16'h1234; op_b = 16'h4321; acarreo = 1'b1;
        @(posedge clk); #1;
        valido = 1'b0;
        checks++; if (o_ocupado !== 1'b1) begin failures++; $display("FAIL bp_ocupado_sumando: got %b want 1", o_ocupado); end
        checks++; if (o_listo !== 1'b0) begin failures++; $display("FAIL bp_listo_sumando: got %b want 0", o_listo); end
        n = 0;
        while (o_valido !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 4) begin failures++; $display("FAIL bp_latencia: got %0d want 4", n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (o_valido !== 1'b1) begin failures++; $display("FAIL bp_valido_hold[%0d]: got %b want 1", i, o_valido); end
            checks++; if (o_suma !== 16'h5556) begin failures++; $display("FAIL bp_suma_hold[%0d]: got %h want 5556", i, o_suma); end
            checks++; if (o_acarreo !== 1'b0) begin failures++; $display("FAIL bp_acarreo_hold[%0d]: got %b want 0", i, o_acarreo); end
            checks++; if (o_listo !== 1'b0) begin failures++; $display("FAIL bp_listo_hold[%0d]: got %b want 0", i, o_listo); end
            @(posedge clk); #1;
        end
        listo = 1'b1;
        @(posedge clk); #1;
        listo = 1'b0;
        checks++; if (o_valido !== 1'b0) begin failures++; $display("FAIL bp_valido_after: got %b want 0", o_valido); end
        checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL bp_listo_after: got %b want 1", o_listo); end
        checks++; if (o_suma !== 16'h5556) begin failures++; $display("FAIL bp_suma_keep: got %h want 5556", o_suma); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a, b; logic [16:0] e1; int n;
        a = 16'($urandom); b = 16'($urandom);
        e1 = modelo16(a, b, 1'b0);
        valido = 1'b1; op_a = a; op_b = b; acarreo = 1'b0;
        @(posedge clk); #1;
        valido = 1'b1; op_a = 16'h000F; op_b = 16'h0001; acarreo = 1'b0;
        n = 0;
        while (o_valido !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_latencia1: got %0d want 4", n); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (o_suma !== e1[15:0]) begin failures++; $display("FAIL b2b_suma1_hold: got %h want %h", o_suma, e1[15:0]); end
        checks++; if (o_listo !== 1'b0) begin failures++; $display("FAIL b2b_listo_entrega: got %b want 0", o_listo); end
        listo = 1'b1;
        @(posedge clk); #1;
        listo = 1'b0;
        checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL b2b_no_bypass: got listo=%b want 1", o_listo); end
        checks++; if (o_suma !== e1[15:0]) begin failures++; $display("FAIL b2b_suma1_keep: got %h want %h", o_suma, e1[15:0]); end
        @(posedge clk); #1;
        valido = 1'b0;
        checks++; if (o_ocupado !== 1'b1) begin failures++; $display("FAIL b2b_accept2: got ocupado=%b want 1", o_ocupado); end
        n = 0;
        while (o_valido !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_latencia2: got %0d want 4", n); end
        checks++; if (o_suma !== 16'h0010) begin failures++; $display("FAIL b2b_suma2: got %h want 0010", o_suma); end
        checks++; if (o_acarreo !== 1'b0) begin failures++; $display("FAIL b2b_acarreo2: got %b want 0", o_acarreo); end
        listo = 1'b1;
        @(posedge clk); #1;
        listo = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat; logic [15:0] s, a, b; logic c, d, ci; logic [16:0] e;
        valido = 1'b1; op_a = 16'hABCD; op_b = 16'h1357; acarreo = 1'b1;
        @(posedge clk); #1;
        valido = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if (o_valido !== 1'b0) begin failures++; $display("FAIL rmid_valido: got %b want 0", o_valido); end
        checks++; if (o_suma !== 16'h0000) begin failures++; $display("FAIL rmid_suma: got %h want 0000", o_suma); end
        checks++; if (o_ocupado !== 1'b0) begin failures++; $display("FAIL rmid_ocupado: got %b want 0", o_ocupado); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL rmid_listo: got %b want 1", o_listo); end
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom_range(0, 1));
        e = modelo16(a, b, ci);
        enviar(a, b, ci, 1, lat, s, c, d);
        checks++; if (s !== e[15:0]) begin failures++; $display("FAIL rmid_new_suma: got %h want %h", s, e[15:0]); end
        checks++; if (c !== e[16]) begin failures++; $display("FAIL rmid_new_acarreo: got %b want %b", c, e[16]); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL rmid_new_latencia: got %0d want 4", lat); end
    endtask

`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
    task automatic test_desborde;
        int lat; logic [15:0] s; logic c, d;
        enviar(16'h7FFF, 16'h0001, 1'b0, 0, lat, s, c, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL desb_7fff_flag: got %b want 1", d); end
        checks++; if (c !== 1'b0) begin failures++; $display("FAIL desb_7fff_acarreo: got %b want 0", c); end
        checks++; if (s !== 16'h8000) begin failures++; $display("FAIL desb_7fff_suma: got %h want 8000", s); end
        enviar(16'hFFFF, 16'h0001, 1'b0, 0, lat, s, c, d);
        checks++; if (d !== 1'b0) begin failures++; $display("FAIL desb_ffff_flag: got %b want 0", d); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL desb_ffff_acarreo: got %b want 1", c); end
    endtask
`endif

    task automatic test_n1;
        int lat; logic [3:0] s; logic c, d;
        enviar1(4'hF, 4'hF, 1'b1, 0, lat, s, c, d);
        checks++; if (s !== 4'hF) begin failures++; $display("FAIL n1_suma: got %h want f", s); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL n1_acarreo: got %b want 1", c); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL n1_latencia: got %0d want 1", lat); end
        checks++; if (ol1 !== 1'b1) begin failures++; $display("FAIL n1_listo_after: got %b want 1", ol1); end
    endtask

    task automatic test_random;
        int lat; logic [15:0] s, a, b; logic [3:0] s4, a4, b4; logic c, d, ci; logic [16:0] e; logic [4:0] e4;
        for (int i = 0; i < 500; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom_range(0, 1));
            if (i % 7 == 0) a = 16'hFFFF;
            e = modelo16(a, b, ci);
            enviar(a, b, ci, int'($urandom_range(0, 3)), lat, s, c, d);
            checks++; if (s !== e[15:0]) begin failures++; $display("FAIL rnd_suma[%0d]: %h+%h+%b got %h want %h", i, a, b, ci, s, e[15:0]); end
            checks++; if (c !== e[16]) begin failures++; $display("FAIL rnd_acarreo[%0d]: got %b want %b", i, c, e[16]); end
            checks++; if (lat !== 4) begin failures++; $display("FAIL rnd_latencia[%0d]: got %0d want 4", i, lat); end
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
            checks++; if (d !== ovf16(a, b, ci)) begin failures++; $display("FAIL rnd_desborde[%0d]: got %b want %b", i, d, ovf16(a, b, ci)); end
`endif
        end
        for (int i = 0; i < 500; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); ci = 1'($urandom_range(0, 1));
            e4 = modelo4(a4, b4, ci);
            enviar1(a4, b4, ci, int'($urandom_range(0, 2)), lat, s4, c, d);
            checks++; if (s4 !== e4[3:0]) begin failures++; $display("FAIL rnd1_suma[%0d]: got %h want %h", i, s4, e4[3:0]); end
            checks++; if (c !== e4[4]) begin failures++; $display("FAIL rnd1_acarreo[%0d]: got %b want %b", i, c, e4[4]); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL rnd1_latencia[%0d]: got %0d want 1", i, lat); end
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
            checks++; if (d !== ovf4(a4, b4, ci)) begin failures++; $display("FAIL rnd1_desborde[%0d]: got %b want %b", i, d, ovf4(a4, b4, ci)); end
`endif
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        valido = 1'b0; listo = 1'b0; acarreo = 1'b0; op_a = '0; op_b = '0;
        v1 = 1'b0; l1 = 1'b0; ci1 = 1'b0; a1 = '0; b1 = '0;
        test_reset();
        test_wrap();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef SUMADOR_MULTINIBBLE_DESBORDE_EN
        test_desborde();
`endif
        test_n1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
